// File: rtl/cntr_ctrl.sv
// Command-driven up-counter with a prescaled tick, terminal-count detection and PAUSE/DONE states.
// Build option: define CNTR_CTRL_AUTORELOAD_EN to wrap to zero at the terminal count instead of stopping.
module cntr_ctrl #(
    parameter int unsigned TICK_DIV = 200000000,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             FPGA_CPU_RESET_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    input  logic [CNT_W-1:0] cfg_limit,
    output logic [CNT_W-1:0] counter_up,
    output logic             tick,
    output logic             wrap,
    output logic [1:0]       state
);

    localparam int unsigned PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StDone  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        OpStart = 2'b00,
        OpStop  = 2'b01,
        OpClear = 2'b10,
        OpLoad  = 2'b11
    } op_e;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    state_e            r_state;
    state_e            w_state_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [PrescW-1:0] r_presc;
    logic [PrescW-1:0] w_presc_d;
    logic              r_tick;
    logic              w_tick_d;
    logic              r_wrap;
    logic              w_wrap_d;
    logic              r_ready;
    logic              w_ready_d;

    logic              w_accept;
    logic              w_evt;
    op_e               w_op;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge CLK or negedge FPGA_CPU_RESET_N) begin
        if (!FPGA_CPU_RESET_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n  = r_rst_sync[1];
    assign w_accept = cmd_valid && r_ready;
    assign w_op     = op_e'(cmd_op);
    assign w_evt    = (r_state == StRun) && (r_presc == PrescMax);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_presc_d = r_presc;
        w_tick_d  = 1'b0;
        w_wrap_d  = 1'b0;
        w_ready_d = !w_accept;

        case (r_state)
            StIdle: begin
                w_presc_d = '0;
                if (w_accept) begin
                    case (w_op)
                        OpStart: w_state_d = StRun;
                        OpLoad:  w_cnt_d   = cmd_data;
                        OpClear: w_cnt_d   = '0;
                        default: ;
                    endcase
                end
            end

            StRun: begin
                // STOP/CLEAR/LOAD win over a coincident tick; START falls through to it.
                if (w_accept && (w_op == OpStop)) begin
                    w_state_d = StPause;
                end else if (w_accept && (w_op == OpClear)) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_presc_d = '0;
                end else if (w_accept && (w_op == OpLoad)) begin
                    w_cnt_d   = cmd_data;
                    w_presc_d = '0;
                end else if (w_evt) begin
                    w_tick_d  = 1'b1;
                    w_presc_d = '0;
                    if (r_cnt == cfg_limit) begin
                        w_wrap_d = 1'b1;
`ifdef CNTR_CTRL_AUTORELOAD_EN
                        w_cnt_d  = '0;
`else
                        w_state_d = StDone;
`endif
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_presc_d = r_presc + PrescW'(1);
                end
            end

            StPause: begin
                if (w_accept) begin
                    case (w_op)
                        OpStart: w_state_d = StRun;
                        OpClear: begin
                            w_state_d = StIdle;
                            w_cnt_d   = '0;
                            w_presc_d = '0;
                        end
                        OpLoad:  w_cnt_d = cmd_data;
                        default: ;
                    endcase
                end
            end

            StDone: begin
                w_presc_d = '0;
                if (w_accept) begin
                    case (w_op)
                        OpStart: begin
                            w_state_d = StRun;
                            w_cnt_d   = '0;
                        end
                        OpClear: begin
                            w_state_d = StIdle;
                            w_cnt_d   = '0;
                        end
                        OpLoad: begin
                            w_state_d = StIdle;
                            w_cnt_d   = cmd_data;
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_presc <= w_presc_d;
            r_tick  <= w_tick_d;
            r_wrap  <= w_wrap_d;
            r_ready <= w_ready_d;
        end
    end

    assign cmd_ready  = r_ready;
    assign counter_up = r_cnt;
    assign tick       = r_tick;
    assign wrap       = r_wrap;
    assign state      = r_state;

endmodule
